fp_exp_align: RTL and testbench

FP_EXP_ALIGN -- requirements
Module: fp_exp_align

---
 rtl/fp_exp_align.sv | 225 ++++++++++++++++++++++
 tb/tb_fp_exp_align.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_exp_align.sv
// ---------------------------------------------------------------------------
// fp_exp_align
//
// Aligns the exponents of two floating-point operands ahead of an adder.
// The operand with the larger exponent (A wins ties) is passed through
// unchanged. The other mantissa gets two zero guard/round bits appended and
// is shifted right by the exponent difference. The shift is done one bit
// per clock and is capped at MAN_W+2, because beyond that nothing is left.
// Every bit shifted out is ORed into sticky.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   operand pair present on ea/eb/ma/mb
//   in_ready   block can accept an operand pair (IDLE only)
//   ea, eb     operand exponents (0 means the operand is zero)
//   ma, mb     operand mantissas, hidden bit included
//   out_valid  aligned result valid (DONE only)
//   out_ready  consumer accepts the result
//   er         larger (result) exponent
//   greater    1 when operand A holds the larger exponent
//   diff       |ea-eb|, EXP_W bits, never saturated
//   m_big      mantissa of the larger-exponent operand
//   m_small    aligned smaller mantissa with 2 guard/round bits
//   sticky     OR of every bit shifted out of m_small
// ---------------------------------------------------------------------------
module fp_exp_align #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP_W-1:0]   ea,
    input  logic [EXP_W-1:0]   eb,
    input  logic [MAN_W-1:0]   ma,
    input  logic [MAN_W-1:0]   mb,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W-1:0]   er,
    output logic               greater,
    output logic [EXP_W-1:0]   diff,
    output logic [MAN_W-1:0]   m_big,
    output logic [MAN_W+1:0]   m_small,
    output logic               sticky
);

    // Width of the aligned mantissa, which is also the largest useful shift.
    localparam int SW    = MAN_W + 2;
    localparam int CNT_W = $clog2(SW + 1);
    localparam int CMP_W = EXP_W + CNT_W;

    localparam logic [CNT_W-1:0] SH_MAX_C     = CNT_W'(SW);
    localparam logic [CMP_W-1:0] SH_MAX_CMP_C = CMP_W'(SW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg,   state_next;
    logic [EXP_W-1:0]   er_reg,      er_next;
    logic               greater_reg, greater_next;
    logic [EXP_W-1:0]   diff_reg,    diff_next;
    logic [MAN_W-1:0]   m_big_reg,   m_big_next;
    logic [SW-1:0]      m_small_reg, m_small_next;
    logic               sticky_reg,  sticky_next;
    logic [CNT_W-1:0]   cnt_reg,     cnt_next;

    // ------------------------------------------------------------------
    // Operand classification at acceptance.
    // ------------------------------------------------------------------
    logic               a_zero;
    logic               b_zero;
    logic               a_ge_b;
    logic [EXP_W-1:0]   exp_diff;
    logic [CMP_W-1:0]   exp_diff_ext;
    logic [CNT_W-1:0]   shift_k;

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_ge_b = (ea >= eb);

    // Modular subtraction. The larger value is always the minuend, so no
    // carry out can occur.
    assign exp_diff     = a_ge_b ? (ea - eb) : (eb - ea);
    assign exp_diff_ext = {{CNT_W{1'b0}}, exp_diff};

    // Cap the shift count. Past SW positions the operand is fully shifted
    // out, so further cycles would not change m_small or sticky.
    assign shift_k = (exp_diff_ext > SH_MAX_CMP_C) ? SH_MAX_C
                                                   : exp_diff_ext[CNT_W-1:0];

    // ------------------------------------------------------------------
    // One-bit right shift with zero fill, written per bit.
    // ------------------------------------------------------------------
    logic [SW-1:0] m_small_shr;

    generate
        for (genvar gi = 0; gi < SW; gi++) begin : g_shr
            if (gi == SW - 1) begin : g_msb
                assign m_small_shr[gi] = 1'b0;
            end else begin : g_body
                assign m_small_shr[gi] = m_small_reg[gi+1];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state and datapath logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        er_next      = er_reg;
        greater_next = greater_reg;
        diff_next    = diff_reg;
        m_big_next   = m_big_reg;
        m_small_next = m_small_reg;
        sticky_next  = sticky_reg;
        cnt_next     = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    sticky_next = 1'b0;
                    cnt_next    = '0;
                    if (a_zero && b_zero) begin
                        er_next      = '0;
                        greater_next = 1'b1;
                        diff_next    = '0;
                        m_big_next   = '0;
                        m_small_next = '0;
                        state_next   = DONE;
                    end else if (a_zero) begin
                        // A is zero, so B passes through and nothing is
                        // aligned. diff still reports the raw difference.
                        er_next      = eb;
                        greater_next = 1'b0;
                        diff_next    = eb;
                        m_big_next   = mb;
                        m_small_next = '0;
                        state_next   = DONE;
                    end else if (b_zero) begin
                        er_next      = ea;
                        greater_next = 1'b1;
                        diff_next    = ea;
                        m_big_next   = ma;
                        m_small_next = '0;
                        state_next   = DONE;
                    end else begin
                        greater_next = a_ge_b;
                        er_next      = a_ge_b ? ea : eb;
                        diff_next    = exp_diff;
                        m_big_next   = a_ge_b ? ma : mb;
                        m_small_next = a_ge_b ? {mb, 2'b00} : {ma, 2'b00};
                        cnt_next     = shift_k;
                        state_next   = (shift_k == '0) ? DONE : SHIFT;
                    end
                end
            end

            SHIFT: begin
                m_small_next = m_small_shr;
                sticky_next  = sticky_reg | m_small_reg[0];
                cnt_next     = cnt_reg - 1'b1;
                // The count is at least 1 on entry. The zero test keeps a
                // corrupted counter from trapping the FSM here.
                if (cnt_reg <= CNT_W'(1)) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers. Reset overrides any handshake.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            er_reg      <= '0;
            greater_reg <= 1'b0;
            diff_reg    <= '0;
            m_big_reg   <= '0;
            m_small_reg <= '0;
            sticky_reg  <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            er_reg      <= er_next;
            greater_reg <= greater_next;
            diff_reg    <= diff_next;
            m_big_reg   <= m_big_next;
            m_small_reg <= m_small_next;
            sticky_reg  <= sticky_next;
            cnt_reg     <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from registers.
    // ------------------------------------------------------------------
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign er        = er_reg;
    assign greater   = greater_reg;
    assign diff      = diff_reg;
    assign m_big     = m_big_reg;
    assign m_small   = m_small_reg;
    assign sticky    = sticky_reg;

endmodule

// File: tb/tb_fp_exp_align.sv
// ---------------------------------------------------------------------------
// tb_fp_exp_align
//
// Directed-vector bench for fp_exp_align (EXP_W=8, MAN_W=24). Each vector
// carries hand-computed expected outputs and latency. Outputs are sampled
// on the falling edge, and inputs are driven on the falling edge.
// ---------------------------------------------------------------------------
module tb_fp_exp_align;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [23:0] ma;
    logic [23:0] mb;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  er;
    logic        greater;
    logic [7:0]  diff;
    logic [23:0] m_big;
    logic [25:0] m_small;
    logic        sticky;

    int n_cmp;
    int n_err;

    fp_exp_align #(
        .EXP_W (8),
        .MAN_W (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ea        (ea),
        .eb        (eb),
        .ma        (ma),
        .mb        (mb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .er        (er),
        .greater   (greater),
        .diff      (diff),
        .m_big     (m_big),
        .m_small   (m_small),
        .sticky    (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".out_valid"}, out_valid, 1'b0);
        chk({name, ".in_ready"},  in_ready,  1'b1);
        chk({name, ".er"},        er,        8'h00);
        chk({name, ".greater"},   greater,   1'b0);
        chk({name, ".diff"},      diff,      8'h00);
        chk({name, ".m_big"},     m_big,     24'h0);
        chk({name, ".m_small"},   m_small,   26'h0);
        chk({name, ".sticky"},    sticky,    1'b0);
    endtask

    task automatic chk_result(input string name,
                              input logic [7:0] x_er, input logic x_gr,
                              input logic [7:0] x_diff, input logic [23:0] x_big,
                              input logic [25:0] x_small, input logic x_st);
        chk({name, ".er"},      er,      x_er);
        chk({name, ".greater"}, greater, x_gr);
        chk({name, ".diff"},    diff,    x_diff);
        chk({name, ".m_big"},   m_big,   x_big);
        chk({name, ".m_small"}, m_small, x_small);
        chk({name, ".sticky"},  sticky,  x_st);
    endtask

    // Issue one operand pair and wait for the result. Latency is counted
    // from the acceptance cycle t0. The result is held for 'hold' cycles
    // under backpressure before the handshake.
    task automatic run_vec(input string name,
                           input logic [7:0] a_e, input logic [7:0] b_e,
                           input logic [23:0] a_m, input logic [23:0] b_m,
                           input logic [7:0] x_er, input logic x_gr,
                           input logic [7:0] x_diff, input logic [23:0] x_big,
                           input logic [25:0] x_small, input logic x_st,
                           input int x_lat, input int hold);
        int lat;
        @(negedge clk);
        chk({name, ".idle_ready"}, in_ready, 1'b1);
        ea        = a_e;
        eb        = b_e;
        ma        = a_m;
        mb        = b_m;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        ea       = 8'h00;
        eb       = 8'h00;
        ma       = 24'h0;
        mb       = 24'h0;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({name, ".latency"}, 64'(lat), 64'(x_lat));
        chk_result(name, x_er, x_gr, x_diff, x_big, x_small, x_st);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, ".hold_valid"}, out_valid, 1'b1);
            chk({name, ".hold_ready"}, in_ready,  1'b0);
            chk_result({name, ".hold"}, x_er, x_gr, x_diff, x_big, x_small, x_st);
        end
        chk({name, ".hs_in_ready"}, in_ready, 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, ".post_valid"}, out_valid, 1'b0);
        chk({name, ".post_ready"}, in_ready,  1'b1);
        $display("vec %s: er=%02h g=%0b diff=%02h m_big=%06h m_small=%07h sticky=%0b lat=%0d",
                 name, er, greater, diff, m_big, m_small, sticky, lat);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ea        = 8'h00;
        eb        = 8'h00;
        ma        = 24'h0;
        mb        = 24'h0;

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        $display("vec reset: in_ready=%0b out_valid=%0b", in_ready, out_valid);

        // Basic alignment by 3 with sticky, plus 5 cycles of backpressure.
        run_vec("diff3",   8'h85, 8'h82, 24'hC00000, 24'hA00001,
                8'h85, 1'b1, 8'h03, 24'hC00000, 26'h0500000, 1'b1, 4, 5);
        // Equal exponents: A wins, no shift.
        run_vec("equal",   8'h7F, 8'h7F, 24'h800000, 24'hFFFFFF,
                8'h7F, 1'b1, 8'h00, 24'h800000, 26'h3FFFFFC, 1'b0, 1, 0);
        // B larger, diff 0x80, shift capped at 26.
        run_vec("cap",     8'h10, 8'h90, 24'h800001, 24'h123456,
                8'h90, 1'b0, 8'h80, 24'h123456, 26'h0, 1'b1, 27, 0);
        // Zero operands.
        run_vec("a_zero",  8'h00, 8'h81, 24'hABCDEF, 24'h900000,
                8'h81, 1'b0, 8'h81, 24'h900000, 26'h0, 1'b0, 1, 0);
        run_vec("b_zero",  8'h81, 8'h00, 24'h900000, 24'hABCDEF,
                8'h81, 1'b1, 8'h81, 24'h900000, 26'h0, 1'b0, 1, 0);
        run_vec("both0",   8'h00, 8'h00, 24'h111111, 24'h222222,
                8'h00, 1'b1, 8'h00, 24'h0, 26'h0, 1'b0, 1, 0);
        // Diff 1, B larger, zero bit shifted out.
        run_vec("diff1",   8'h40, 8'h41, 24'h800002, 24'h800000,
                8'h41, 1'b0, 8'h01, 24'h800000, 26'h1000004, 1'b0, 2, 0);
        // Diff exactly 26: everything shifted out.
        run_vec("diff26",  8'h9A, 8'h80, 24'h800000, 24'h800000,
                8'h9A, 1'b1, 8'h1A, 24'h800000, 26'h0, 1'b1, 27, 0);
        // Diff 25: a single bit survives.
        run_vec("diff25",  8'h99, 8'h80, 24'h800000, 24'hC00000,
                8'h99, 1'b1, 8'h19, 24'h800000, 26'h1, 1'b1, 26, 0);
        // Largest difference, not saturated in diff.
        run_vec("diffFE",  8'hFF, 8'h01, 24'hFFFFFF, 24'hFFFFFF,
                8'hFF, 1'b1, 8'hFE, 24'hFFFFFF, 26'h0, 1'b1, 27, 0);

        // Reset in the 3rd SHIFT cycle of the capped case.
        @(negedge clk);
        ea = 8'h10; eb = 8'h90; ma = 24'h800001; mb = 24'h123456;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);                 // cycle t0+1, 1st SHIFT
        in_valid = 1'b0;
        chk("midrst.shifting", in_ready, 1'b0);
        @(negedge clk);                 // t0+2
        @(negedge clk);                 // t0+3, 3rd SHIFT
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("midrst");
        repeat (30) @(negedge clk);
        chk("midrst.stay_idle", out_valid, 1'b0);
        $display("vec midrst: in_ready=%0b out_valid=%0b", in_ready, out_valid);

        // Reset wins over a handshake in the same cycle.
        @(negedge clk);
        ea = 8'h85; eb = 8'h82; ma = 24'hC00000; mb = 24'hA00001;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rsths.in_done", out_valid, 1'b1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk_all_zero("rsths");
        $display("vec rsths: in_ready=%0b out_valid=%0b", in_ready, out_valid);

        // Recovery after reset.
        run_vec("recover", 8'h85, 8'h82, 24'hC00000, 24'hA00001,
                8'h85, 1'b1, 8'h03, 24'hC00000, 26'h0500000, 1'b1, 4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
